// File: rtl/hasti_uart.sv
// HASTI peripheral-bus UART: zero-wait-state register slave, divisor-timed TX/RX framing, FIFOs, level irq.
// Optional parity (CTRL[2] par_en, CTRL[3] par_odd, STATUS[6] parity_err) is built when HASTI_UART_PARITY_EN is defined.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif

module hasti_uart #(
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter logic [15:0] DIV_RESET = 16'd867
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [`HASTI_ADDR_WIDTH-1:0] addr,
    input  logic                         read,
    input  logic                         write,
    input  logic [`HASTI_SIZE_WIDTH-1:0] size,
    input  logic [`HASTI_BUS_WIDTH-1:0]  wdata,
    output logic [`HASTI_BUS_WIDTH-1:0]  rdata,
    output logic                         ready,
    output logic                         resp,
    input  logic                         rxd,
    output logic                         txd,
    output logic                         irq
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_ONE = {{TX_AW{1'b0}}, 1'b1};
    localparam logic [RX_AW:0] RX_ONE = {{RX_AW{1'b0}}, 1'b1};
    localparam logic [1:0] A_DIV = 2'd0, A_STATUS = 2'd1, A_DATA = 2'd2, A_CTRL = 2'd3;
    localparam logic [`HASTI_SIZE_WIDTH-1:0] SZ_BYTE = '0;
    localparam logic [`HASTI_SIZE_WIDTH-1:0] SZ_HALF = {{(`HASTI_SIZE_WIDTH-1){1'b0}}, 1'b1};
`ifdef HASTI_UART_PARITY_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h3;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Bus address phase and register state
    logic [1:0]  reg_addr_q, reg_addr_d;
    logic [1:0]  be_q, be_d;
    logic        wr_q, wr_d, rd_q, rd_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [3:0]  flags_q, flags_d;  // {parity_err, tx_drop, frame_err, rx_overrun}
    logic        irq_q, irq_d;

    // FIFOs
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [TX_AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RX_AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic           tx_empty, tx_full, rx_empty, rx_full;
    logic           tx_push, tx_pop, rx_push, rx_pop, tx_drop_set, tx_idle;

    // TX FSM
    state_t      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d, tx_head;
    logic        tx_par_q, tx_par_d, txd_q, txd_d;

    // RX FSM
    state_t      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
    logic        frame_set, overrun_set, parity_set;

    logic        par_en, par_odd, bus_data_wr;
    logic [6:0]  status;
    logic        unused_bits;

    assign ready = 1'b1;
    assign resp  = 1'b0;
    assign txd   = txd_q;
    assign irq   = irq_q;
    assign par_en  = ctrl_q[2];
    assign par_odd = ctrl_q[3];
    assign unused_bits = ^{addr[`HASTI_ADDR_WIDTH-1:4], wdata[`HASTI_BUS_WIDTH-1:16]};

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[TX_AW] != tx_rp_q[TX_AW]) && (tx_wp_q[TX_AW-1:0] == tx_rp_q[TX_AW-1:0]);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[RX_AW] != rx_rp_q[RX_AW]) && (rx_wp_q[RX_AW-1:0] == rx_rp_q[RX_AW-1:0]);
    assign tx_idle  = tx_empty && (tx_state_q == S_IDLE);
    assign tx_head  = tx_mem[tx_rp_q[TX_AW-1:0]];

    assign bus_data_wr = wr_q && (reg_addr_q == A_DATA) && be_q[0];
    assign tx_push     = bus_data_wr && !tx_full;
    assign tx_drop_set = bus_data_wr && tx_full;
    assign rx_pop      = rd_q && (reg_addr_q == A_DATA) && !rx_empty;
    assign status      = {flags_q, tx_idle, tx_full, rx_empty};

    // Address phase capture; only byte lanes 0 and 1 carry writable bits
    always_comb begin
        reg_addr_d = addr[3:2];
        wr_d       = write;
        rd_d       = read;
        if (size == SZ_BYTE)
            be_d = {addr[1:0] == 2'd1, addr[1:0] == 2'd0};
        else if (size == SZ_HALF)
            be_d = {~addr[1], ~addr[1]};
        else
            be_d = 2'b11;
    end

    always_comb begin
        div_d  = div_q;
        ctrl_d = ctrl_q;
        if (wr_q && reg_addr_q == A_DIV) begin
            if (be_q[0]) div_d[7:0]  = wdata[7:0];
            if (be_q[1]) div_d[15:8] = wdata[15:8];
        end
        if (wr_q && reg_addr_q == A_CTRL && be_q[0])
            ctrl_d = wdata[3:0] & CTRL_MASK;
        flags_d = flags_q;
        if (wr_q && reg_addr_q == A_STATUS && be_q[0])
            flags_d = flags_q & ~wdata[6:3];
        flags_d = flags_d | {parity_set, tx_drop_set, frame_set, overrun_set};
        irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_idle) |
                flags_q[0] | flags_q[1] | flags_q[3];
    end

    always_comb begin
        rdata = '0;
        case (reg_addr_q)
            A_DIV:    rdata[15:0] = div_q;
            A_STATUS: rdata[6:0]  = status;
            A_DATA:   if (!rx_empty) rdata[7:0] = rx_mem[rx_rp_q[RX_AW-1:0]];
            default:  rdata[3:0]  = ctrl_q;
        endcase
    end

    always_comb begin
        tx_wp_d = tx_wp_q + (tx_push ? TX_ONE : '0);
        tx_rp_d = tx_rp_q + (tx_pop ? TX_ONE : '0);
        rx_wp_d = rx_wp_q + (rx_push ? RX_ONE : '0);
        rx_rp_d = rx_rp_q + (rx_pop ? RX_ONE : '0);
    end

    // TX: every state lasts DIV+1 clocks; STOP chains straight into the next START
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        if (tx_state_q != S_IDLE && tx_cnt_q != 16'd0) begin
            tx_cnt_d = tx_cnt_q - 16'd1;
        end else begin
            tx_cnt_d = div_q;
            case (tx_state_q)
                S_START: begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                end
                S_DATA: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = par_en ? S_PARITY : S_STOP;
                        txd_d      = par_en ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end
                S_PARITY: begin
                    tx_state_d = S_STOP;
                    txd_d      = 1'b1;
                end
                default: begin
                    tx_state_d = S_IDLE;
                    txd_d      = 1'b1;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_par_d   = (^tx_head) ^ par_odd;
                        tx_state_d = S_START;
                        txd_d      = 1'b0;
                    end
                end
            endcase
        end
    end

    // RX: start validated half a bit after the falling edge, later bits sampled one bit period apart
    always_comb begin
        rx_meta_d   = rxd;
        rx_sync_d   = rx_meta_q;
        rx_prev_d   = rx_sync_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        frame_set   = 1'b0;
        overrun_set = 1'b0;
        parity_set  = 1'b0;
        if (rx_state_q == S_IDLE) begin
            if (rx_prev_q && !rx_sync_q) begin
                rx_state_d = S_START;
                rx_cnt_d   = (div_q >> 1) - {15'd0, ~div_q[0]};
            end
        end else if (rx_cnt_q != 16'd0) begin
            rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
            rx_cnt_d = div_q;
            case (rx_state_q)
                S_START: begin
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                    rx_bit_d   = 3'd0;
                end
                S_DATA: begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7)
                        rx_state_d = par_en ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    parity_set = rx_sync_q != ((^rx_shift_q) ^ par_odd);
                    rx_state_d = S_STOP;
                end
                default: begin
                    rx_state_d = S_IDLE;
                    if (!rx_sync_q)
                        frame_set = 1'b1;
                    else if (rx_full && !rx_pop)
                        overrun_set = 1'b1;
                    else
                        rx_push = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[TX_AW-1:0]] <= wdata[7:0];
        if (rx_push) rx_mem[rx_wp_q[RX_AW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_addr_q <= A_DIV;
            be_q       <= 2'b00;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            div_q      <= DIV_RESET;
            ctrl_q     <= 4'h0;
            flags_q    <= 4'h0;
            irq_q      <= 1'b0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            reg_addr_q <= reg_addr_d;
            be_q       <= be_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            div_q      <= div_d;
            ctrl_q     <= ctrl_d;
            flags_q    <= flags_d;
            irq_q      <= irq_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
        end
    end
endmodule

// File: tb/tb_hasti_uart.sv
// Directed/randomized bench for hasti_uart: bus register checks, TX line decoding, RX frame driving vs a queue model.
`timescale 1ns/1ps
module tb_hasti_uart;
    localparam int TXD = 16;
    localparam int RXD = 16;
    localparam logic [31:0] A_DIV = 32'h0, A_STATUS = 32'h4, A_DATA = 32'h8, A_CTRL = 32'hC;
`ifdef HASTI_UART_PARITY_EN
    localparam logic [31:0] CTRL_EXP = 32'hF;
`else
    localparam logic [31:0] CTRL_EXP = 32'h3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [2:0]  size = 3'd2;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready, resp;
    logic        rxd = 1'b1;
    logic        txd, irq;

    int total = 0;
    int bad = 0;
    int tb_div = 867;
    logic [7:0] rx_model[$];

    always #5 clk = ~clk;

    hasti_uart #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DIV_RESET(16'd867)) dut (
        .clk(clk), .reset(reset), .addr(addr), .read(read), .write(write), .size(size),
        .wdata(wdata), .rdata(rdata), .ready(ready), .resp(resp), .rxd(rxd), .txd(txd), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        @(negedge clk);
        addr = a; size = sz; write = 1'b1; read = 1'b0;
        @(negedge clk);
        write = 1'b0; wdata = d;
        $display("write addr=%h data=%h size=%0d", a, d, sz);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; size = 3'd2; read = 1'b1; write = 1'b0;
        @(negedge clk);
        read = 1'b0; d = rdata;
        $display("read  addr=%h data=%h", a, d);
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic set_div(input int v);
        bus_write(A_DIV, v, 3'd2);
        tb_div = v;
    endtask

    // Drives one frame on rxd; par < 0 means no parity bit
    task automatic send_frame(input logic [7:0] b, input logic stop, input int par);
        int p = tb_div + 1;
        @(negedge clk);
        rxd = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (p) @(negedge clk);
        end
        if (par >= 0) begin
            rxd = par[0];
            repeat (p) @(negedge clk);
        end
        rxd = stop;
        repeat (p) @(negedge clk);
        rxd = 1'b1;
        repeat (stop ? 3 : p) @(negedge clk);
        $display("rx frame byte=%h stop=%0d par=%0d", b, stop, par);
    endtask

    task automatic send_model(input logic [7:0] b);
        send_frame(b, 1'b1, -1);
        if (rx_model.size() < RXD) rx_model.push_back(b);
    endtask

    // Decodes one frame from txd, sampling mid-bit; returns at the middle of the stop bit
    task automatic tx_capture(output logic [7:0] b, output bit ok);
        int n = 0;
        int p = tb_div + 1;
        b = '0;
        ok = 1'b0;
        while (txd !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (txd !== 1'b0) return;
        repeat (p / 2) @(negedge clk);
        ok = (txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (p) @(negedge clk);
            b[i] = txd;
        end
        repeat (p) @(negedge clk);
        ok = ok && (txd === 1'b1);
        $display("tx frame byte=%h ok=%0d", b, ok);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  b, b2;
        logic [9:0]  frame;
        logic [3:0]  s;
        bit          ok;
        int          n;
        logic [7:0]  burst [TXD+2];
        logic [7:0]  got [TXD+1];
        bit          got_ok [TXD+1];
        logic        txd_min;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_txd", {31'b0, txd}, 32'h1);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check_reg("rst_status", A_STATUS, 32'h5);
        check_reg("rst_div", A_DIV, 32'h363);
        check_reg("rst_ctrl", A_CTRL, 32'h0);
        check_reg("rst_data_empty", A_DATA, 32'h0);

        // Byte enables on DIV: byte lane 1 writes, halfword at offset 2 misses DIV entirely
        bus_write(A_DIV + 32'h1, 32'h0000_AB00, 3'd0);
        check_reg("div_byte1", A_DIV, 32'hAB63);
        bus_write(A_DIV + 32'h2, 32'h1234_5678, 3'd1);
        check_reg("div_half_hi", A_DIV, 32'hAB63);
        bus_write(A_CTRL, 32'hFF, 3'd2);
        check_reg("ctrl_mask", A_CTRL, CTRL_EXP);
        bus_write(A_CTRL, 32'h0, 3'd2);

        // Exact TX waveform for 0xA5 at 4 clocks per bit
        set_div(3);
        bus_write(A_DATA, 32'hA5, 3'd0);
        n = 0;
        while (txd !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("a5_start_seen", {31'b0, txd}, 32'h0);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) begin
                s[j] = txd;
                @(negedge clk);
            end
            check($sformatf("a5_bit%0d", k), {28'b0, s}, {28'b0, {4{frame[k]}}});
        end
        check_reg("a5_tx_idle", A_STATUS, 32'h5);

        b = 8'($urandom);
        bus_write(A_DATA, {24'b0, b}, 3'd2);
        tx_capture(b2, ok);
        check("tx_rand_frame_ok", {31'b0, ok}, 32'h1);
        check("tx_rand_byte", {24'b0, b2}, {24'b0, b});
        repeat (4) @(negedge clk);

        // Back-to-back pipelined writes: one pops at once, TX_DEPTH fill the FIFO, the last drops
        for (int i = 0; i < TXD + 2; i++) burst[i] = 8'($urandom);
        fork
            begin
                for (int i = 0; i <= TXD + 2; i++) begin
                    @(negedge clk);
                    if (i > 0) wdata = {24'b0, burst[i-1]};
                    write = (i < TXD + 2);
                    addr = A_DATA;
                    size = 3'd2;
                    read = 1'b0;
                end
                check_reg("burst_status_full_drop", A_STATUS, 32'h23);
            end
            begin
                for (int i = 0; i < TXD + 1; i++) tx_capture(got[i], got_ok[i]);
            end
        join
        for (int i = 0; i < TXD + 1; i++) begin
            check($sformatf("burst_ok%0d", i), {31'b0, got_ok[i]}, 32'h1);
            check($sformatf("burst_byte%0d", i), {24'b0, got[i]}, {24'b0, burst[i]});
        end
        repeat (4) @(negedge clk);
        check_reg("burst_drop_before_clr", A_STATUS, 32'h25);
        bus_write(A_STATUS, 32'h20, 3'd2);
        check_reg("burst_drop_cleared", A_STATUS, 32'h5);

        // RX single byte
        set_div(7);
        send_frame(8'h3C, 1'b1, -1);
        check_reg("rx_3c_status", A_STATUS, 32'h4);
        check_reg("rx_3c_data", A_DATA, 32'h3C);
        check_reg("rx_3c_empty_again", A_STATUS, 32'h5);

        for (int i = 0; i < 3; i++) send_model(8'($urandom));
        for (int i = 0; i < 3; i++) begin
            bus_read(A_DATA, v);
            check($sformatf("rx_rand%0d", i), v, {24'b0, rx_model.pop_front()});
        end

        // Interrupt enables
        bus_write(A_CTRL, 32'h1, 3'd2);
        repeat (2) @(negedge clk);
        check("irq_rx_en_empty", {31'b0, irq}, 32'h0);
        send_model(8'($urandom));
        check("irq_rx_nonempty", {31'b0, irq}, 32'h1);
        bus_read(A_DATA, v);
        check("irq_rx_byte", v, {24'b0, rx_model.pop_front()});
        repeat (2) @(negedge clk);
        check("irq_rx_drained", {31'b0, irq}, 32'h0);
        bus_write(A_CTRL, 32'h2, 3'd2);
        repeat (2) @(negedge clk);
        check("irq_tx_idle", {31'b0, irq}, 32'h1);
        bus_write(A_CTRL, 32'h0, 3'd2);
        repeat (2) @(negedge clk);

        // Overrun: RX_DEPTH+1 frames unread
        for (int i = 0; i < RXD + 1; i++) send_model(8'($urandom));
        check_reg("ovr_status", A_STATUS, 32'hC);
        check("ovr_irq", {31'b0, irq}, 32'h1);
        for (int i = 0; i < RXD; i++) begin
            bus_read(A_DATA, v);
            check($sformatf("ovr_byte%0d", i), v, {24'b0, rx_model.pop_front()});
        end
        check_reg("ovr_drained", A_STATUS, 32'hD);
        bus_write(A_STATUS, 32'h8, 3'd2);
        check_reg("ovr_cleared", A_STATUS, 32'h5);
        check("ovr_irq_cleared", {31'b0, irq}, 32'h0);

        // Framing error
        send_frame(8'($urandom), 1'b0, -1);
        check_reg("ferr_status", A_STATUS, 32'h15);
        check("ferr_irq", {31'b0, irq}, 32'h1);
        check_reg("ferr_no_push", A_DATA, 32'h0);
        bus_write(A_STATUS, 32'h10, 3'd2);
        check_reg("ferr_cleared", A_STATUS, 32'h5);

        // Two-clock glitch is a false start
        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check_reg("glitch_ignored", A_STATUS, 32'h5);

`ifdef HASTI_UART_PARITY_EN
        bus_write(A_CTRL, 32'h4, 3'd2);
        b = 8'($urandom);
        b2 = 8'($urandom);
        send_frame(b, 1'b1, int'(^b));
        check_reg("par_good_status", A_STATUS, 32'h4);
        send_frame(b2, 1'b1, int'(~^b2));
        check_reg("par_bad_status", A_STATUS, 32'h44);
        check_reg("par_byte0", A_DATA, {24'b0, b});
        check_reg("par_byte1", A_DATA, {24'b0, b2});
        bus_write(A_STATUS, 32'h40, 3'd2);
        bus_write(A_CTRL, 32'h0, 3'd2);
        check_reg("par_cleared", A_STATUS, 32'h5);
`endif

        // Reset in the middle of a TX frame (inside data bit 0 of 0x5A, which is low)
        set_div(3);
        bus_write(A_DATA, 32'h5A, 3'd2);
        n = 0;
        while (txd !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("midreset_line_low", {31'b0, txd}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_txd_high", {31'b0, txd}, 32'h1);
        reset = 1'b0;
        check_reg("midreset_status", A_STATUS, 32'h5);
        check_reg("midreset_div", A_DIV, 32'h363);
        txd_min = 1'b1;
        repeat (60) begin
            @(negedge clk);
            txd_min = txd_min & txd;
        end
        check("midreset_frame_lost", {31'b0, txd_min}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
